sc_trace_buffer: RTL

SC_TRACE_BUFFER -- requirements
Module: sc_trace_buffer

---
 rtl/sc_trace_buffer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/sc_trace_buffer.sv
// rtl/sc_trace_buffer.sv - CPU retirement trace capture into a first-word-fall-through FIFO
//
// Captures {pc, inst, aluout} of retired instructions into a DEPTH-entry FWFT
// FIFO during an armed/triggered capture session of up to CAPTURE_LEN samples.
//
// Ports:
//   clock, reset              single clock, synchronous active-high reset
//   pc, inst, aluout          CPU sample fields, qualified by sample_valid
//   start, stop, clear        session control pulses (clear also flushes the FIFO)
//   trigger_en, trigger_pc    optional start-of-capture address trigger
//   rd_ready / rd_valid       FIFO read handshake, head shown on rd_pc/rd_inst/rd_aluout
//   count                     entries held (0..DEPTH)
//   overflow                  sticky, a qualified sample was dropped while full
//   state                     IDLE=00, ARMED=01, CAPTURE=10, DONE=11
module sc_trace_buffer #(
  parameter int DEPTH       = 16,
  parameter int CAPTURE_LEN = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [31:0]               pc,
  input  logic [31:0]               inst,
  input  logic [31:0]               aluout,
  input  logic                      sample_valid,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      clear,
  input  logic                      trigger_en,
  input  logic [31:0]               trigger_pc,
  input  logic                      rd_ready,
  output logic                      rd_valid,
  output logic [31:0]               rd_pc,
  output logic [31:0]               rd_inst,
  output logic [31:0]               rd_aluout,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic [1:0]                state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [7:0]  LAST_CNT = 8'(CAPTURE_LEN - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARMED   = 2'b01,
    CAPTURE = 2'b10,
    DONE    = 2'b11
  } state_t;

  state_t        state_q;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic [7:0]    cap_cnt;
  logic          overflow_q;
  logic [95:0]   mem [DEPTH];

  logic in_session;
  logic stop_act;
  logic start_act;
  logic hit;
  logic capture_push;
  logic last_sample;
  logic fifo_full;
  logic do_pop;
  logic do_push;
  logic do_drop;

  always_comb begin
    in_session   = (state_q == ARMED) || (state_q == CAPTURE);
    stop_act     = stop && in_session;
    start_act    = start && !in_session;
    // ARMED only qualifies on the trigger address; CAPTURE takes every valid sample.
    hit          = sample_valid &&
                   ((state_q == CAPTURE) ||
                    ((state_q == ARMED) && (!trigger_en || (pc == trigger_pc))));
    // stop outranks capture, so the stop cycle's sample is not taken.
    capture_push = !clear && !stop_act && hit;
    last_sample  = capture_push && (cap_cnt == LAST_CNT);
    fifo_full    = (count_q == FULL_CNT);
    do_pop       = !clear && (count_q != '0) && rd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    do_push      = capture_push && (!fifo_full || do_pop);
    do_drop      = capture_push && fifo_full && !do_pop;
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      state_q    <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      cap_cnt    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (stop_act) begin
        state_q <= DONE;
      end else if (start_act) begin
        state_q <= ARMED;
        cap_cnt <= '0;
      end else if (capture_push) begin
        // Dropped samples still consume session length.
        cap_cnt <= cap_cnt + 8'd1;
        state_q <= last_sample ? DONE : CAPTURE;
      end

      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_drop) overflow_q <= 1'b1;

      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; contents are only observable while rd_valid is high.
  always_ff @(posedge clock) begin
    if (!reset && do_push) mem[wr_ptr] <= {pc, inst, aluout};
  end

  assign {rd_pc, rd_inst, rd_aluout} = mem[rd_ptr];
  assign rd_valid = (count_q != '0);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign state    = state_q;

endmodule
